// File: rtl/machine_trap_unit_if.sv
// rtl/machine_trap_unit_if.sv - execute/fetch side bundle of the machine trap unit
interface machine_trap_unit_if;
   logic        csr_req;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        exc_valid;
   logic [3:0]  exc_code;
   logic [31:0] exc_pc;
   logic [31:0] exc_tval;
   logic        irq_meip;
   logic        irq_mtip;
   logic        irq_msip;
   logic        boundary;
   logic [31:0] next_pc;
   logic        mret;
   logic        trap_redirect;
   logic [31:0] trap_target;

   modport master (
      output csr_req, csr_op, csr_addr, csr_wdata,
      output exc_valid, exc_code, exc_pc, exc_tval,
      output irq_meip, irq_mtip, irq_msip, boundary, next_pc, mret,
      input  csr_rdata, csr_illegal, trap_redirect, trap_target
   );

   modport slave (
      input  csr_req, csr_op, csr_addr, csr_wdata,
      input  exc_valid, exc_code, exc_pc, exc_tval,
      input  irq_meip, irq_mtip, irq_msip, boundary, next_pc, mret,
      output csr_rdata, csr_illegal, trap_redirect, trap_target
   );
endinterface

// File: rtl/machine_trap_unit.sv
// rtl/machine_trap_unit.sv - M-mode CSRs, trap/interrupt arbitration, mret and fetch redirect
module machine_trap_unit #(
   parameter int          XLEN        = 32,
   parameter logic [31:0] HART_ID     = 32'd0,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input logic               clk,
   input logic               rst,
   machine_trap_unit_if.slave bus
);
   localparam logic [0:0]      ST_RUN      = 1'b0;
   localparam logic [0:0]      ST_REDIRECT = 1'b1;
   localparam logic [XLEN-1:0] MISA_VAL    = 32'h4000_1100;
   localparam logic [XLEN-1:0] MIE_MASK    = 32'h0000_0888;

   logic [0:0]      state_q, state_d;
   logic            st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
   logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
   logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
   logic            trap_redirect_q, trap_redirect_d;
   logic [XLEN-1:0] trap_target_q, trap_target_d;

   logic [XLEN-1:0] mstatus_rd, mip_rd, pending, rdata, wval, tvec_base, target;
   logic            impl, is_write, illegal, irq_any, in_run;
   logic            exc_take, irq_take, mret_take, trap_take, csr_we;
   logic [3:0]      irq_code, trap_code;

   assign mstatus_rd = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, st_mpie_q, 3'b000, st_mie_q, 3'b000};
   assign mip_rd     = {{(XLEN-12){1'b0}}, bus.irq_meip, 3'b000, bus.irq_mtip, 3'b000,
                        bus.irq_msip, 3'b000};

   always_comb begin
      rdata = '0;
      impl  = 1'b1;
      case (bus.csr_addr)
         12'h300: rdata = mstatus_rd;
         12'h310: rdata = '0;
         12'h301: rdata = MISA_VAL;
         12'h304: rdata = mie_q;
         12'h344: rdata = mip_rd;
         12'h305: rdata = mtvec_q;
         12'h340: rdata = mscratch_q;
         12'h341: rdata = mepc_q;
         12'h342: rdata = mcause_q;
         12'h343: rdata = mtval_q;
         12'hF11, 12'hF12, 12'hF13: rdata = '0;
         12'hF14: rdata = HART_ID;
         default: impl = 1'b0;
      endcase
   end

   // Set/clear with a zero operand is a pure read, so it is legal even in read-only space
   assign is_write = bus.csr_req && ((bus.csr_op == 2'b01) || (bus.csr_op[1] && (|bus.csr_wdata)));
   assign illegal  = bus.csr_req && (!impl || (is_write && (bus.csr_addr[11:10] == 2'b11)));

   always_comb begin
      case (bus.csr_op)
         2'b01:   wval = bus.csr_wdata;
         2'b10:   wval = rdata | bus.csr_wdata;
         2'b11:   wval = rdata & ~bus.csr_wdata;
         default: wval = rdata;
      endcase
   end

   assign pending = mip_rd & mie_q;
   assign irq_any = pending[11] | pending[3] | pending[7];
   assign irq_code = pending[11] ? 4'd11 : (pending[3] ? 4'd3 : 4'd7);

   assign in_run    = (state_q == ST_RUN);
   assign exc_take  = in_run && bus.exc_valid;
   assign irq_take  = in_run && !bus.exc_valid && bus.boundary && st_mie_q && irq_any;
   assign mret_take = in_run && !bus.exc_valid && !irq_take && bus.mret;
   assign trap_take = exc_take || irq_take;
   assign csr_we    = in_run && is_write && !illegal && !trap_take && !mret_take;
   assign trap_code = exc_take ? bus.exc_code : irq_code;

   assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
   assign target    = (mtvec_q[0] && irq_take) ? tvec_base + {{(XLEN-6){1'b0}}, trap_code, 2'b00}
                                               : tvec_base;

   always_comb begin
      state_d         = state_q;
      st_mie_d        = st_mie_q;
      st_mpie_d       = st_mpie_q;
      mie_d           = mie_q;
      mtvec_d         = mtvec_q;
      mscratch_d      = mscratch_q;
      mepc_d          = mepc_q;
      mcause_d        = mcause_q;
      mtval_d         = mtval_q;
      trap_redirect_d = 1'b0;
      trap_target_d   = trap_target_q;
      if (state_q == ST_REDIRECT) begin
         state_d = ST_RUN;
      end else if (trap_take) begin
         mepc_d          = exc_take ? {bus.exc_pc[XLEN-1:2], 2'b00} : {bus.next_pc[XLEN-1:2], 2'b00};
         mcause_d        = {irq_take, {(XLEN-5){1'b0}}, trap_code};
         mtval_d         = exc_take ? bus.exc_tval : '0;
         st_mpie_d       = st_mie_q;
         st_mie_d        = 1'b0;
         trap_redirect_d = 1'b1;
         trap_target_d   = target;
         state_d         = ST_REDIRECT;
      end else if (mret_take) begin
         st_mie_d        = st_mpie_q;
         st_mpie_d       = 1'b1;
         trap_redirect_d = 1'b1;
         trap_target_d   = mepc_q;
         state_d         = ST_REDIRECT;
      end else if (csr_we) begin
         case (bus.csr_addr)
            12'h300: begin
               st_mie_d  = wval[3];
               st_mpie_d = wval[7];
            end
            12'h304: mie_d      = wval & MIE_MASK;
            12'h305: mtvec_d    = {wval[XLEN-1:2], 1'b0, wval[0]};
            12'h340: mscratch_d = wval;
            12'h341: mepc_d     = {wval[XLEN-1:2], 2'b00};
            12'h342: mcause_d   = wval;
            12'h343: mtval_d    = wval;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_RUN;
         st_mie_q        <= 1'b0;
         st_mpie_q       <= 1'b0;
         mie_q           <= '0;
         mtvec_q         <= {MTVEC_RESET[XLEN-1:2], 1'b0, MTVEC_RESET[0]};
         mscratch_q      <= '0;
         mepc_q          <= '0;
         mcause_q        <= '0;
         mtval_q         <= '0;
         trap_redirect_q <= 1'b0;
         trap_target_q   <= '0;
      end else begin
         state_q         <= state_d;
         st_mie_q        <= st_mie_d;
         st_mpie_q       <= st_mpie_d;
         mie_q           <= mie_d;
         mtvec_q         <= mtvec_d;
         mscratch_q      <= mscratch_d;
         mepc_q          <= mepc_d;
         mcause_q        <= mcause_d;
         mtval_q         <= mtval_d;
         trap_redirect_q <= trap_redirect_d;
         trap_target_q   <= trap_target_d;
      end
   end

   assign bus.csr_rdata     = rdata;
   assign bus.csr_illegal   = illegal;
   assign bus.trap_redirect = trap_redirect_q;
   assign bus.trap_target   = trap_target_q;
endmodule

// File: tb/tb_machine_trap_unit.sv
// tb/tb_machine_trap_unit.sv - scoreboard bench for machine_trap_unit
module tb_machine_trap_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   machine_trap_unit_if bus ();

   machine_trap_unit #(
      .XLEN        (32),
      .HART_ID     (32'd2),
      .MTVEC_RESET (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] redir_q[$];
   logic [31:0] rd_q[$];
   logic        prev_redir = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step_begin();
      @(posedge clk);
      #1;
      bus.csr_req   = 1'b0;
      bus.csr_op    = 2'b00;
      bus.csr_addr  = 12'h000;
      bus.csr_wdata = 32'h0;
      bus.exc_valid = 1'b0;
      bus.exc_code  = 4'd0;
      bus.exc_pc    = 32'h0;
      bus.exc_tval  = 32'h0;
      bus.boundary  = 1'b0;
      bus.next_pc   = 32'h0;
      bus.mret      = 1'b0;
   endtask

   task automatic csr_read(input logic [11:0] addr, input logic [31:0] exp, input string tag);
      step_begin();
      bus.csr_req  = 1'b1;
      bus.csr_addr = addr;
      rd_q.push_back(exp);
      @(negedge clk);
      check_eq(tag, bus.csr_rdata, rd_q.pop_front());
   endtask

   task automatic csr_write(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data,
                            input logic exp_ill);
      step_begin();
      bus.csr_req   = 1'b1;
      bus.csr_op    = op;
      bus.csr_addr  = addr;
      bus.csr_wdata = data;
      @(negedge clk);
      check_eq($sformatf("illegal_%h_op%0d", addr, op), {31'b0, bus.csr_illegal}, {31'b0, exp_ill});
   endtask

   // Every redirect pulse must be expected, last one cycle, and carry the queued target
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.trap_redirect) begin
            check_eq("redir_pulse_len", {31'b0, prev_redir}, 32'd0);
            if (redir_q.size() == 0)
               check_eq("redir_unexpected", {31'b0, bus.trap_redirect}, 32'd0);
            else
               check_eq("redir_target", bus.trap_target, redir_q.pop_front());
         end
         prev_redir = bus.trap_redirect;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog n_checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bus.irq_meip = 1'b0;
      bus.irq_mtip = 1'b0;
      bus.irq_msip = 1'b0;
      repeat (3) step_begin();
      @(negedge clk);
      check_eq("rst_redirect", {31'b0, bus.trap_redirect}, 32'd0);
      check_eq("rst_target", bus.trap_target, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      csr_read(12'h300, 32'h0000_1800, "rst_mstatus");
      csr_read(12'h301, 32'h4000_1100, "misa");
      csr_read(12'hF14, 32'd2, "mhartid");
      csr_read(12'h305, 32'h0, "rst_mtvec");
      csr_read(12'h341, 32'h0, "rst_mepc");

      csr_write(12'h340, 2'b01, 32'h0000_1234, 1'b0);
      csr_write(12'h300, 2'b10, 32'h0000_0008, 1'b0);
      csr_write(12'h305, 2'b01, 32'h8000_0103, 1'b0);
      csr_read(12'h305, 32'h8000_0101, "mtvec_bit1");

      step_begin();
      bus.exc_valid = 1'b1;
      bus.exc_code  = 4'd2;
      bus.exc_pc    = 32'h100;
      bus.exc_tval  = 32'hDEAD;
      redir_q.push_back(32'h8000_0100);
      step_begin();
      bus.exc_valid = 1'b1;
      bus.exc_code  = 4'd7;
      bus.exc_pc    = 32'h500;
      bus.exc_tval  = 32'hBEEF;
      bus.csr_req   = 1'b1;
      bus.csr_addr  = 12'h342;
      @(negedge clk);
      check_eq("exc_redirect_hi", {31'b0, bus.trap_redirect}, 32'd1);
      check_eq("exc_mcause_early", bus.csr_rdata, 32'd2);
      csr_read(12'h341, 32'h100, "exc_mepc");
      csr_read(12'h343, 32'hDEAD, "exc_mtval_dropped");
      csr_read(12'h300, 32'h0000_1880, "exc_mstatus");

      step_begin();
      bus.exc_valid = 1'b1;
      bus.exc_code  = 4'd4;
      bus.exc_pc    = 32'h302;
      bus.exc_tval  = 32'h77;
      bus.csr_req   = 1'b1;
      bus.csr_op    = 2'b01;
      bus.csr_addr  = 12'h340;
      bus.csr_wdata = 32'hFFFF;
      redir_q.push_back(32'h8000_0100);
      step_begin();
      csr_read(12'h341, 32'h300, "b2b_mepc_align");
      step_begin();
      bus.exc_valid = 1'b1;
      bus.exc_code  = 4'd5;
      bus.exc_pc    = 32'h308;
      bus.exc_tval  = 32'h99;
      redir_q.push_back(32'h8000_0100);
      step_begin();
      csr_read(12'h340, 32'h1234, "mscratch_suppressed");
      csr_read(12'h341, 32'h308, "b2b_mepc");
      csr_read(12'h342, 32'd5, "b2b_mcause");
      csr_read(12'h343, 32'h99, "b2b_mtval");
      csr_read(12'h300, 32'h0000_1800, "b2b_mstatus");

      csr_write(12'h305, 2'b01, 32'h8000_0001, 1'b0);
      csr_write(12'h304, 2'b01, 32'hFFFF_FFFF, 1'b0);
      csr_read(12'h304, 32'h0000_0888, "mie_mask");
      csr_write(12'h300, 2'b01, 32'h0000_0008, 1'b0);
      csr_read(12'h300, 32'h0000_1808, "mstatus_mie");
      bus.irq_mtip = 1'b1;
      bus.irq_msip = 1'b1;
      csr_read(12'h344, 32'h0000_0088, "mip_pins");
      step_begin();
      bus.boundary = 1'b1;
      bus.next_pc  = 32'h204;
      redir_q.push_back(32'h8000_000C);
      step_begin();
      bus.irq_mtip = 1'b0;
      bus.irq_msip = 1'b0;
      csr_read(12'h342, 32'h8000_0003, "irq_mcause");
      csr_read(12'h341, 32'h204, "irq_mepc");
      csr_read(12'h343, 32'h0, "irq_mtval");
      csr_read(12'h300, 32'h0000_1880, "irq_mstatus");

      step_begin();
      bus.mret = 1'b1;
      redir_q.push_back(32'h204);
      step_begin();
      csr_read(12'h300, 32'h0000_1888, "mret_mstatus");

      csr_write(12'hF11, 2'b01, 32'h5, 1'b1);
      step_begin();
      bus.csr_req  = 1'b1;
      bus.csr_addr = 12'h7C0;
      @(negedge clk);
      check_eq("illegal_7c0_read", {31'b0, bus.csr_illegal}, 32'd1);
      csr_write(12'hF11, 2'b10, 32'h0, 1'b0);
      csr_read(12'hF11, 32'h0, "f11_reads0");
      csr_read(12'h340, 32'h1234, "mscratch_final");

      repeat (2) step_begin();
      check_eq("redir_missing", 32'(redir_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/machine_trap_unit.md
# machine_trap_unit

Machine-mode trap and CSR unit for the CPU-X RV32 core. It is the consumer/writer side of the machine CSR bit encodings in `csr_pkg`. The unit holds the implemented M-mode CSRs and serves CSR instruction reads and writes from execute. It arbitrates synchronous exceptions against external, timer and software interrupts, and performs trap entry and `mret` state updates. It also issues a registered one-cycle PC redirect to fetch.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `HART_ID`, 0: value returned by `mhartid`.
- `MTVEC_RESET`, 32'h0000_0000: reset value of `mtvec`.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `csr_req`  in  1  CSR instruction present this cycle.
- `csr_op`  in  2  01 write, 10 set, 11 clear, 00 read-only.
- `csr_addr`  in  12  CSR address.
- `csr_wdata`  in  32  write/set/clear operand.
- `csr_rdata`  out  32  combinational pre-update value of `csr_addr`.
- `csr_illegal`  out  1  combinational: unimplemented address, or a write to the read-only space.
- `exc_valid`  in  1  synchronous exception from the instruction at `exc_pc`.
- `exc_code`  in  4  `MCAUSE_CODE_EXCEPTION_*` value.
- `exc_pc`  in  32  PC of the faulting instruction.
- `exc_tval`  in  32  value written to `mtval`.
- `irq_meip`, `irq_mtip`, `irq_msip`  in  1 each  level-sensitive interrupt pins.
- `boundary`  in  1  an instruction retires this cycle; `next_pc` is valid.
- `next_pc`  in  32  PC of the next instruction, saved on interrupt.
- `mret`  in  1  `mret` executing this cycle.
- `trap_redirect`  out  1  registered one-cycle redirect pulse.
- `trap_target`  out  32  registered redirect PC.

## Operation
- Implemented CSRs:
  - 0x300 `mstatus`: only MIE and MPIE are writable; MPP always reads 2'b11; all other bits read 0.
  - 0x310 `mstatush`: reads 0; writes are ignored.
  - 0x301 `misa`: reads 32'h4000_1100; writes are ignored.
  - 0x304 `mie`: bits 11, 7 and 3 are writable.
  - 0x344 `mip`: reads the pins on bits 11, 7 and 3; writes are ignored.
  - 0x305 `mtvec`: bit 1 is forced to 0.
  - 0x340 `mscratch`.
  - 0x341 `mepc`: bits [1:0] are forced to 0.
  - 0x342 `mcause`, 0x343 `mtval`.
  - 0xF11–0xF13: read 0.
  - 0xF14: reads `HART_ID`.
- Write data by op: new = wdata (01), old | wdata (10), old & ~wdata (11).
- A set or clear with `csr_wdata == 0` is not a write.
- `csr_illegal` asserts for any unlisted address, or for a write when `csr_addr[11:10] == 2'b11`. An illegal access updates no state.
- Priority within a cycle, highest first:
  - exception;
  - interrupt, taken only when `boundary` is high and `mstatus.MIE` is set;
  - `mret`;
  - CSR write.
  - A taken trap or `mret` suppresses any CSR write in the same cycle.
- Interrupt selection: pending = `mip & mie`; order is MEI (11) > MSI (3) > MTI (7).
- Trap entry, at the edge:
  - `mepc` ← `exc_pc` for an exception, `next_pc` for an interrupt, with bits [1:0] cleared;
  - `mcause` ← {is_irq, code};
  - `mtval` ← `exc_tval` for an exception, 0 for an interrupt;
  - MPIE ← MIE, then MIE ← 0.
- Target PC:
  - `{mtvec[31:2], 2'b00}`;
  - plus 4·code when `mtvec[0] == 1` and the trap is an interrupt.
- `mret`: MIE ← MPIE, MPIE ← 1; target = `mepc`.
- FSM:
  - RUN: a trap or `mret` registers the target and moves to REDIRECT.
  - REDIRECT: `trap_redirect` = 1 for exactly this cycle. `exc_valid`, `mret`, CSR writes and interrupts are ignored (the pipeline is flushing). Returns to RUN.

## Timing
- Reset values:
  - `trap_redirect` 0, `trap_target` 0, FSM in RUN;
  - `mstatus` reads 32'h0000_1800;
  - `mtvec` = `MTVEC_RESET`;
  - `mie`, `mepc`, `mcause`, `mtval`, `mscratch` = 0.
- Reset mid-REDIRECT returns to RUN with `trap_redirect` 0 on the next cycle.
- `csr_rdata` and `csr_illegal` have zero latency. A write is visible to a read in the following cycle.
- Redirect latency: an event in cycle N gives `trap_redirect` in cycle N+1. The CSRs are already updated in cycle N+1.
- Interrupt pins are sampled combinationally; no synchronizer is included. A pin deasserting before `boundary` means no trap.
- Back-to-back: an exception in the REDIRECT cycle is dropped. One in the following RUN cycle is taken.

## Test plan
- Reset, then read 0x300, 0x301 and 0xF14 (`HART_ID`=2) -> 32'h0000_1800, 32'h4000_1100 and 2. `trap_redirect` stays 0.
- Write `mtvec` = 32'h8000_0103, then `exc_valid`, code 2, pc 32'h100, tval 32'hDEAD with MIE=1 -> next cycle:
  - `trap_target` = 32'h8000_0100, `trap_redirect` = 1 for one cycle;
  - `mcause` = 2, `mepc` = 32'h100, `mtval` = 32'hDEAD;
  - `mstatus` = 32'h0000_1880.
- Vectored mode: `mtvec` = 32'h8000_0001, `mie` = 32'h888, MIE=1, `irq_mtip` and `irq_msip` high, `boundary`, `next_pc` = 32'h204 ->
  - MSI wins: `mcause` = 32'h8000_0003, `trap_target` = 32'h8000_000C, `mepc` = 32'h204.
- `mret` after the previous case -> `trap_target` = 32'h204, MIE=1, MPIE=1.
- Same-cycle `exc_valid` plus a CSR write of `mscratch` -> `mscratch` unchanged. An exception in the REDIRECT cycle is ignored.
- Write to 0xF11, read of 0x7C0, and set of 0xF11 with wdata 0 -> `csr_illegal` is 1, 1 and 0 respectively; no state change.
